ctrl_id_seq: RTL and testbench
==============================

// Module: ctrl_id_seq
// PURPOSE
//  Parametrised successor to the decode-stage control. Registers the ID->EX control word (IR, ALU select,
//  memory access/mode) with a valid/ready handshake, stall hold and flush. Adds a micro-sequencer that
//  expands multi-register transfers (PUSH/POP/STMIA/LDMIA) into one EX beat per listed register.
//  Sits between the fetch IR register and the EX stage.
// PARAMETERS
//  IR_W     16  instruction width; decode fields are taken from bits [15:0]
//  RLIST_W   8  low-register list width (r0..r(RLIST_W-1))
//  OFS_W     6  width of o_offset_r, the byte offset; must hold 4*(RLIST_W+1)-4
// PORTS
//  clk                   in   1        clock
//  rst                   in   1        synchronous reset, active-high
//  i_valid               in   1        i_ir holds a valid instruction
//  i_ir                  in   IR_W     instruction from fetch
//  o_ready               out  1        ID accepts i_ir this cycle (combinational)
//  i_stall               in   1        EX cannot take a beat; hold all registered outputs
//  i_flush               in   1        branch taken; kill ID contents and any sequence
//  o_valid_r             out  1        EX beat valid
//  o_ir_ex_r             out  IR_W     instruction of the current beat
//  o_alu_sel_r           out  3        ADD=000 MV_IMM=001 MV_REG=010 SUB=101
//  o_mem_data_access_r   out  4        0 = no data access, 2 = word data access
//  o_mem_rd_mode_r       out  2        NONE=0 16=1 32=2 8=3
//  o_mem_wr_mode_r       out  2        same encoding as o_mem_rd_mode_r
//  o_reg_idx_r           out  4        register transferred by this sequence beat
//  o_offset_r            out  OFS_W    byte offset from base = 4*beat number
//  o_first_r/o_last_r    out  1 each   first/last beat of the instruction (both 1 for single-beat)
// BEHAVIOUR
//  Reset or flush: o_valid_r=0, o_ir_ex_r=0, alu=MV_IMM, access=0, rd=16, wr=NONE, reg_idx=0,
//   offset=0, first=last=0, state=DECODE. i_flush wins over i_stall and i_valid in the same cycle.
//  o_ready = (state==DECODE) & ~i_stall & ~i_flush.
//  Stall: every registered output and the state/list registers hold. Nothing is updated when i_stall=1.
//  DECODE, accept (i_valid & o_ready): register the decode 1 cycle later. Non-accept, no stall: o_valid_r=0.
//   Single-beat table on ir[15:7]: 0001110?? ADD, 10101???? ADD, 101100001 SUB, 00100???? MV_IMM,
//   01000110? MV_REG, 11100???? ADD, 1101????? ADD, 00101???? SUB. Any other code: MV_IMM.
//   LDR on ir[15:11] 01101 or 01001: access=2, rd=32, wr=NONE, alu=ADD.
//   STR on ir[15:11] 01100: access=2, rd=NONE, wr=32, alu=ADD. All other instructions: access=0, rd=16, wr=NONE.
//  Multi-register instructions; the list is L={extra, ir[RLIST_W-1:0]}:
//   PUSH 1011010x: extra=x maps to r14, store.  POP 1011110x: extra=x maps to r15, load.
//   STMIA 11000: extra=0, store.  LDMIA 11001: extra=0, load.
//   Per beat: alu=ADD, access=2, load rd=32/wr=NONE, store rd=NONE/wr=32, o_ir_ex_r=ir for every beat.
//   L==0: one beat with access=0, rd=16, wr=NONE, first=last=1; no sequence is entered.
//   popcount(L)==1: one beat with first=last=1; stay in DECODE.
//   popcount(L)>1: the accept cycle emits the lowest set bit with first=1, offset=0. Go to SEQ and latch
//   the remaining list.
//  SEQ, each non-stalled cycle: emit the lowest remaining set bit, offset+=4, clear that bit.
//   o_last_r=1 on the beat that empties the list; the next state is DECODE.
//  Register order is ascending, and the extra bit is always last. There are no bubbles between beats.
//  Beat count of an N-register instruction = N (minimum 1). The following instruction is accepted
//   in the cycle after last.
// TESTING
//  rst for 2 cycles -> all outputs at reset values; o_ready=1 once rst drops.
//  ir=0x6808 (LDR) valid, no stall -> next cycle valid=1, alu=000, access=2, rd=2, wr=0, first=last=1.
//  ir=0xB5F0 (PUSH {r4-r7,lr}) -> 5 beats, reg_idx 4,5,6,7,14, offset 0,4,8,12,16, wr=2;
//   o_ready=0 for 4 cycles; last=1 on reg_idx 14.
//  LDMIA list 0x05; i_stall high on beat 2 for 3 cycles -> outputs frozen (reg_idx=2, offset=4); sequence resumes.
//  POP {r0-r3,pc} with i_flush on beat 3 -> next cycle valid=0, state=DECODE, o_ready=1, reset outputs.
//  ir=0xC000 (STMIA empty list) -> one beat, access=0, first=last=1; the next instruction is accepted next cycle.

Source files
------------

// File: rtl/ctrl_id_seq.sv
// ID->EX control register with valid/ready handshake, stall hold and flush, plus a
// micro-sequencer that expands PUSH/POP/STMIA/LDMIA into one EX beat per listed register.
module ctrl_id_seq #(
  parameter int IR_W    = 16,
  parameter int RLIST_W = 8,
  parameter int OFS_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [IR_W-1:0]  i_ir,
  output logic             o_ready,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic             o_valid_r,
  output logic [IR_W-1:0]  o_ir_ex_r,
  output logic [2:0]       o_alu_sel_r,
  output logic [3:0]       o_mem_data_access_r,
  output logic [1:0]       o_mem_rd_mode_r,
  output logic [1:0]       o_mem_wr_mode_r,
  output logic [3:0]       o_reg_idx_r,
  output logic [OFS_W-1:0] o_offset_r,
  output logic             o_first_r,
  output logic             o_last_r,
  output logic             dbg_state
);

  // Handshake: an instruction transfers on a cycle where i_valid & o_ready are both 1;
  // o_ready is combinational and never depends on i_valid. i_stall freezes every register,
  // i_flush clears them and has priority over both i_stall and i_valid.

  localparam int LW = RLIST_W + 1;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_MV_IMM = 3'b001;
  localparam logic [2:0] ALU_MV_REG = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b101;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_16   = 2'd1;
  localparam logic [1:0] MEM_32   = 2'd2;

  localparam logic [3:0] ACC_NONE = 4'd0;
  localparam logic [3:0] ACC_WORD = 4'd2;

  typedef enum logic {DECODE = 1'b0, SEQ = 1'b1} state_t;

  state_t          state, n_state;
  logic [LW-1:0]   rem_r, n_rem;
  logic [3:0]      extra_r, n_extra;

  logic             n_valid;
  logic [IR_W-1:0]  n_ir;
  logic [2:0]       n_alu;
  logic [3:0]       n_acc;
  logic [1:0]       n_rd;
  logic [1:0]       n_wr;
  logic [3:0]       n_reg;
  logic [OFS_W-1:0] n_offset;
  logic             n_first;
  logic             n_last;

  logic [15:0]   d;
  logic [2:0]    dec_alu;
  logic          is_ldr, is_str, is_push, is_pop, is_stm, is_ldm, is_multi, is_load_multi;
  logic [LW-1:0] dec_list;
  logic [3:0]    dec_xidx;

  logic [LW-1:0] src_list, low_bit, after_list;
  logic [3:0]    src_xidx, pick_idx;

  // Maps a one-hot list bit to a register number; the top bit stands for r14/r15.
  function automatic logic [3:0] bit_idx(input logic [LW-1:0] onehot, input logic [3:0] xidx);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < LW; i++) begin
      if (onehot[i]) r = (i == RLIST_W) ? xidx : 4'(i);
    end
    return r;
  endfunction

  assign d = i_ir[15:0];

  always_comb begin
    dec_alu = ALU_MV_IMM;
    if (d[15:9] == 7'b0001110)      dec_alu = ALU_ADD;
    else if (d[15:11] == 5'b10101)  dec_alu = ALU_ADD;
    else if (d[15:7] == 9'b101100001) dec_alu = ALU_SUB;
    else if (d[15:11] == 5'b00100)  dec_alu = ALU_MV_IMM;
    else if (d[15:8] == 8'b01000110) dec_alu = ALU_MV_REG;
    else if (d[15:11] == 5'b11100)  dec_alu = ALU_ADD;
    else if (d[15:12] == 4'b1101)   dec_alu = ALU_ADD;
    else if (d[15:11] == 5'b00101)  dec_alu = ALU_SUB;
  end

  assign is_ldr        = (d[15:11] == 5'b01101) || (d[15:11] == 5'b01001);
  assign is_str        = (d[15:11] == 5'b01100);
  assign is_push       = (d[15:9] == 7'b1011010);
  assign is_pop        = (d[15:9] == 7'b1011110);
  assign is_stm        = (d[15:11] == 5'b11000);
  assign is_ldm        = (d[15:11] == 5'b11001);
  assign is_multi      = is_push | is_pop | is_stm | is_ldm;
  assign is_load_multi = is_pop | is_ldm;
  assign dec_list      = {(is_push | is_pop) & d[8], d[RLIST_W-1:0]};
  assign dec_xidx      = is_pop ? 4'd15 : 4'd14;

  // One priority picker serves both the accept beat and the SEQ beats.
  assign src_list   = (state == SEQ) ? rem_r : dec_list;
  assign src_xidx   = (state == SEQ) ? extra_r : dec_xidx;
  assign low_bit    = src_list & ((~src_list) + {{(LW-1){1'b0}}, 1'b1});
  assign after_list = src_list & ~low_bit;
  assign pick_idx   = bit_idx(low_bit, src_xidx);

  assign o_ready   = (state == DECODE) & ~i_stall & ~i_flush;
  assign dbg_state = state;

  always_comb begin
    n_state  = state;
    n_rem    = rem_r;
    n_extra  = extra_r;
    n_valid  = o_valid_r;
    n_ir     = o_ir_ex_r;
    n_alu    = o_alu_sel_r;
    n_acc    = o_mem_data_access_r;
    n_rd     = o_mem_rd_mode_r;
    n_wr     = o_mem_wr_mode_r;
    n_reg    = o_reg_idx_r;
    n_offset = o_offset_r;
    n_first  = o_first_r;
    n_last   = o_last_r;
    if (i_flush) begin
      n_state  = DECODE;
      n_rem    = '0;
      n_extra  = '0;
      n_valid  = 1'b0;
      n_ir     = '0;
      n_alu    = ALU_MV_IMM;
      n_acc    = ACC_NONE;
      n_rd     = MEM_16;
      n_wr     = MEM_NONE;
      n_reg    = '0;
      n_offset = '0;
      n_first  = 1'b0;
      n_last   = 1'b0;
    end else if (!i_stall) begin
      case (state)
        DECODE: begin
          if (i_valid) begin
            n_valid  = 1'b1;
            n_ir     = i_ir;
            n_first  = 1'b1;
            n_last   = 1'b1;
            n_offset = '0;
            n_reg    = '0;
            if (is_multi) begin
              n_alu = ALU_ADD;
              if (dec_list == '0) begin
                n_acc = ACC_NONE;
                n_rd  = MEM_16;
                n_wr  = MEM_NONE;
              end else begin
                n_acc = ACC_WORD;
                n_rd  = is_load_multi ? MEM_32 : MEM_NONE;
                n_wr  = is_load_multi ? MEM_NONE : MEM_32;
                n_reg = pick_idx;
                if (after_list != '0) begin
                  n_last  = 1'b0;
                  n_state = SEQ;
                  n_rem   = after_list;
                  n_extra = dec_xidx;
                end
              end
            end else begin
              n_alu = dec_alu;
              if (is_ldr) begin
                n_alu = ALU_ADD;
                n_acc = ACC_WORD;
                n_rd  = MEM_32;
                n_wr  = MEM_NONE;
              end else if (is_str) begin
                n_alu = ALU_ADD;
                n_acc = ACC_WORD;
                n_rd  = MEM_NONE;
                n_wr  = MEM_32;
              end else begin
                n_acc = ACC_NONE;
                n_rd  = MEM_16;
                n_wr  = MEM_NONE;
              end
            end
          end else begin
            n_valid = 1'b0;
          end
        end
        SEQ: begin
          // Memory mode, ALU select and IR carry over unchanged from the accept beat.
          n_valid  = 1'b1;
          n_reg    = pick_idx;
          n_offset = o_offset_r + OFS_W'(4);
          n_first  = 1'b0;
          n_rem    = after_list;
          n_last   = (after_list == '0);
          if (after_list == '0) n_state = DECODE;
        end
        default: n_state = DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= DECODE;
      rem_r               <= '0;
      extra_r             <= '0;
      o_valid_r           <= 1'b0;
      o_ir_ex_r           <= '0;
      o_alu_sel_r         <= ALU_MV_IMM;
      o_mem_data_access_r <= ACC_NONE;
      o_mem_rd_mode_r     <= MEM_16;
      o_mem_wr_mode_r     <= MEM_NONE;
      o_reg_idx_r         <= '0;
      o_offset_r          <= '0;
      o_first_r           <= 1'b0;
      o_last_r            <= 1'b0;
    end else begin
      state               <= n_state;
      rem_r               <= n_rem;
      extra_r             <= n_extra;
      o_valid_r           <= n_valid;
      o_ir_ex_r           <= n_ir;
      o_alu_sel_r         <= n_alu;
      o_mem_data_access_r <= n_acc;
      o_mem_rd_mode_r     <= n_rd;
      o_mem_wr_mode_r     <= n_wr;
      o_reg_idx_r         <= n_reg;
      o_offset_r          <= n_offset;
      o_first_r           <= n_first;
      o_last_r            <= n_last;
    end
  end

endmodule

// File: tb/tb_ctrl_id_seq.sv
// Directed bench for ctrl_id_seq: table of single-beat decodes plus hand-written
// sequences for multi-register beats, stall hold, flush and empty lists.
module tb_ctrl_id_seq;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_ir;
  logic        o_ready;
  logic        i_stall;
  logic        i_flush;
  logic        o_valid_r;
  logic [15:0] o_ir_ex_r;
  logic [2:0]  o_alu_sel_r;
  logic [3:0]  o_mem_data_access_r;
  logic [1:0]  o_mem_rd_mode_r;
  logic [1:0]  o_mem_wr_mode_r;
  logic [3:0]  o_reg_idx_r;
  logic [5:0]  o_offset_r;
  logic        o_first_r;
  logic        o_last_r;
  logic        dbg_state;

  int checks = 0;
  int failures = 0;

  ctrl_id_seq dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_valid             (i_valid),
    .i_ir                (i_ir),
    .o_ready             (o_ready),
    .i_stall             (i_stall),
    .i_flush             (i_flush),
    .o_valid_r           (o_valid_r),
    .o_ir_ex_r           (o_ir_ex_r),
    .o_alu_sel_r         (o_alu_sel_r),
    .o_mem_data_access_r (o_mem_data_access_r),
    .o_mem_rd_mode_r     (o_mem_rd_mode_r),
    .o_mem_wr_mode_r     (o_mem_wr_mode_r),
    .o_reg_idx_r         (o_reg_idx_r),
    .o_offset_r          (o_offset_r),
    .o_first_r           (o_first_r),
    .o_last_r            (o_last_r),
    .dbg_state           (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input logic valid, input logic [15:0] ir,
                          input logic [3:0] acc, input logic [1:0] rd, input logic [1:0] wr,
                          input logic [3:0] idx, input logic [5:0] ofs,
                          input logic first, input logic last);
    chk({name, ".valid"}, 32'(o_valid_r), 32'(valid));
    chk({name, ".ir"}, 32'(o_ir_ex_r), 32'(ir));
    chk({name, ".access"}, 32'(o_mem_data_access_r), 32'(acc));
    chk({name, ".rd"}, 32'(o_mem_rd_mode_r), 32'(rd));
    chk({name, ".wr"}, 32'(o_mem_wr_mode_r), 32'(wr));
    chk({name, ".reg_idx"}, 32'(o_reg_idx_r), 32'(idx));
    chk({name, ".offset"}, 32'(o_offset_r), 32'(ofs));
    chk({name, ".first"}, 32'(o_first_r), 32'(first));
    chk({name, ".last"}, 32'(o_last_r), 32'(last));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk_beat(name, 1'b0, 16'h0000, 4'd0, 2'd1, 2'd0, 4'd0, 6'd0, 1'b0, 1'b0);
    chk({name, ".alu"}, 32'(o_alu_sel_r), 32'd1);
    chk({name, ".state"}, 32'(dbg_state), 32'd0);
  endtask

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  alu;
    logic [3:0]  acc;
    logic [1:0]  rd;
    logic [1:0]  wr;
  } vec_t;

  vec_t vecs[14];

  int push_idx[5] = '{4, 5, 6, 7, 14};

  initial begin
    vecs[0]  = '{16'h6808, 3'b000, 4'd2, 2'd2, 2'd0};  // LDR
    vecs[1]  = '{16'h4800, 3'b000, 4'd2, 2'd2, 2'd0};  // LDR literal
    vecs[2]  = '{16'h6000, 3'b000, 4'd2, 2'd0, 2'd2};  // STR
    vecs[3]  = '{16'h1C00, 3'b000, 4'd0, 2'd1, 2'd0};
    vecs[4]  = '{16'hA800, 3'b000, 4'd0, 2'd1, 2'd0};
    vecs[5]  = '{16'hB080, 3'b101, 4'd0, 2'd1, 2'd0};
    vecs[6]  = '{16'h2000, 3'b001, 4'd0, 2'd1, 2'd0};
    vecs[7]  = '{16'h4600, 3'b010, 4'd0, 2'd1, 2'd0};
    vecs[8]  = '{16'h4680, 3'b010, 4'd0, 2'd1, 2'd0};
    vecs[9]  = '{16'hE000, 3'b000, 4'd0, 2'd1, 2'd0};
    vecs[10] = '{16'hD000, 3'b000, 4'd0, 2'd1, 2'd0};
    vecs[11] = '{16'h2800, 3'b101, 4'd0, 2'd1, 2'd0};
    vecs[12] = '{16'h0000, 3'b001, 4'd0, 2'd1, 2'd0};
    vecs[13] = '{16'h4000, 3'b001, 4'd0, 2'd1, 2'd0};

    rst = 1'b1; i_valid = 1'b0; i_ir = 16'h0; i_stall = 1'b0; i_flush = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    #1;
    chk("reset.ready", 32'(o_ready), 32'd1);

    // Back-to-back single-beat decodes.
    for (int v = 0; v < 14; v++) begin
      i_valid = 1'b1;
      i_ir = vecs[v].ir;
      #1;
      chk($sformatf("vec%0d.ready", v), 32'(o_ready), 32'd1);
      tick();
      chk_beat($sformatf("vec%0d", v), 1'b1, vecs[v].ir, vecs[v].acc, vecs[v].rd, vecs[v].wr,
               4'd0, 6'd0, 1'b1, 1'b1);
      chk($sformatf("vec%0d.alu", v), 32'(o_alu_sel_r), 32'(vecs[v].alu));
    end
    i_valid = 1'b0;
    tick();
    chk("idle.valid", 32'(o_valid_r), 32'd0);

    // PUSH {r4-r7,lr}: five store beats, ready low on the first four.
    i_valid = 1'b1; i_ir = 16'hB5F0;
    tick();
    i_valid = 1'b0;
    for (int b = 0; b < 5; b++) begin
      if (b > 0) tick();
      chk_beat($sformatf("push.b%0d", b), 1'b1, 16'hB5F0, 4'd2, 2'd0, 2'd2,
               4'(push_idx[b]), 6'(4 * b), (b == 0), (b == 4));
      chk($sformatf("push.b%0d.alu", b), 32'(o_alu_sel_r), 32'd0);
      chk($sformatf("push.b%0d.ready", b), 32'(o_ready), (b == 4) ? 32'd1 : 32'd0);
    end
    tick();
    chk("push.after.valid", 32'(o_valid_r), 32'd0);

    // LDMIA {r0,r2} with a 3-cycle stall on beat 2.
    i_valid = 1'b1; i_ir = 16'hC805;
    tick();
    i_valid = 1'b0;
    chk_beat("ldm.b0", 1'b1, 16'hC805, 4'd2, 2'd2, 2'd0, 4'd0, 6'd0, 1'b1, 1'b0);
    tick();
    chk_beat("ldm.b1", 1'b1, 16'hC805, 4'd2, 2'd2, 2'd0, 4'd2, 6'd4, 1'b0, 1'b1);
    i_stall = 1'b1;
    #1;
    chk("ldm.stall.ready", 32'(o_ready), 32'd0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk_beat($sformatf("ldm.stall%0d", s), 1'b1, 16'hC805, 4'd2, 2'd2, 2'd0, 4'd2, 6'd4,
               1'b0, 1'b1);
    end
    i_stall = 1'b0;
    #1;
    chk("ldm.resume.ready", 32'(o_ready), 32'd1);
    tick();
    chk("ldm.after.valid", 32'(o_valid_r), 32'd0);
    chk("ldm.after.state", 32'(dbg_state), 32'd0);

    // POP {r0-r3,pc} flushed on beat 3; a concurrent valid instruction must be dropped.
    i_valid = 1'b1; i_ir = 16'hBD0F;
    tick();
    i_valid = 1'b0;
    chk_beat("pop.b0", 1'b1, 16'hBD0F, 4'd2, 2'd2, 2'd0, 4'd0, 6'd0, 1'b1, 1'b0);
    tick();
    chk("pop.b1.reg_idx", 32'(o_reg_idx_r), 32'd1);
    tick();
    chk_beat("pop.b2", 1'b1, 16'hBD0F, 4'd2, 2'd2, 2'd0, 4'd2, 6'd8, 1'b0, 1'b0);
    chk("pop.b2.state", 32'(dbg_state), 32'd1);
    i_flush = 1'b1; i_valid = 1'b1; i_ir = 16'h6808;
    #1;
    chk("pop.flush.ready", 32'(o_ready), 32'd0);
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    #1;
    chk_reset_outputs("pop.flush");
    chk("pop.flush.ready_after", 32'(o_ready), 32'd1);

    // STMIA with empty list, immediately followed by a STR.
    i_valid = 1'b1; i_ir = 16'hC000;
    tick();
    chk_beat("stm0", 1'b1, 16'hC000, 4'd0, 2'd1, 2'd0, 4'd0, 6'd0, 1'b1, 1'b1);
    chk("stm0.ready", 32'(o_ready), 32'd1);
    i_ir = 16'h6000;
    tick();
    chk_beat("stm0.next", 1'b1, 16'h6000, 4'd2, 2'd0, 2'd2, 4'd0, 6'd0, 1'b1, 1'b1);

    // PUSH {lr} alone: single beat carrying r14.
    i_ir = 16'hB500;
    tick();
    i_valid = 1'b0;
    chk_beat("push_lr", 1'b1, 16'hB500, 4'd2, 2'd0, 2'd2, 4'd14, 6'd0, 1'b1, 1'b1);
    chk("push_lr.state", 32'(dbg_state), 32'd0);
    tick();
    chk("push_lr.after.valid", 32'(o_valid_r), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
